// File: rtl/addsub_pipe.sv
// Two-stage add/sub/accumulate pipeline with valid/ready on both sides.
// S1 holds the operands, S2 holds the result; the accumulator advances when an ACC/CLR leaves S1.
module addsub_pipe #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic [1:0]       op_out
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   logic             s1_valid_q, s2_valid_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic [1:0]       op_q, op_out_q;
   logic             carry_q;

   logic             s2_load, s1_adv, in_fire;
   logic [WIDTH:0]   add_w, sub_w, acc_w;
   logic [WIDTH-1:0] result_d;
   logic             carry_d;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_load;
   assign in_ready = !reset && (!s1_valid_q || s2_load);
   assign in_fire  = in_valid && in_ready;

   assign add_w = {1'b0, a_q} + {1'b0, b_q};
   assign sub_w = {1'b0, b_q} - {1'b0, a_q};
   assign acc_w = {1'b0, acc_q} + {1'b0, a_q};

   // Bit WIDTH of the subtraction is the borrow, i.e. (b < a).
   always_comb begin
      result_d = '0;
      carry_d  = 1'b0;
      case (op_q)
         OP_ADD: begin
            carry_d  = add_w[WIDTH];
            result_d = (SATURATE != 0 && carry_d) ? '1 : add_w[WIDTH-1:0];
         end
         OP_SUB: begin
            carry_d  = sub_w[WIDTH];
            result_d = (SATURATE != 0 && carry_d) ? '0 : sub_w[WIDTH-1:0];
         end
         OP_ACC: begin
            carry_d  = acc_w[WIDTH];
            result_d = (SATURATE != 0 && carry_d) ? '1 : acc_w[WIDTH-1:0];
         end
         default: begin
            carry_d  = 1'b0;
            result_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         op_out_q   <= '0;
      end else begin
         if (in_fire) begin
            s1_valid_q <= 1'b1;
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
         end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
         end
         // Payload only moves on a real advance so a stalled result stays stable.
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_adv) begin
               result_q <= result_d;
               carry_q  <= carry_d;
               op_out_q <= op_q;
            end
         end
         if (s1_adv && (op_q == OP_ACC || op_q == OP_CLR))
            acc_q <= result_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign op_out    = op_out_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_addsub_pipe;

   logic       clk = 1'b0;
   logic       reset, in_valid, out_ready;
   logic [7:0] a, b;
   logic [1:0] op;
   logic       in_ready0, out_valid0, carry0, in_ready1, out_valid1, carry1;
   logic [7:0] result0, result1;
   logic [1:0] op_out0, op_out1;
   int         nvec = 0;
   int         nerr = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(8), .SATURATE(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
      .result(result0), .carry(carry0), .op_out(op_out0));

   addsub_pipe #(.WIDTH(8), .SATURATE(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
      .result(result1), .carry(carry1), .op_out(op_out1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Check the output of both instances: valid, result, carry.
   task automatic chk_out(input string tag, input logic v, input logic [7:0] r0,
                          input logic [7:0] r1, input logic c, input logic [1:0] o);
      chk({tag, ".v0"}, 32'(out_valid0), 32'(v));
      chk({tag, ".v1"}, 32'(out_valid1), 32'(v));
      if (v) begin
         chk({tag, ".r0"}, 32'(result0), 32'(r0));
         chk({tag, ".r1"}, 32'(result1), 32'(r1));
         chk({tag, ".c0"}, 32'(carry0), 32'(c));
         chk({tag, ".c1"}, 32'(carry1), 32'(c));
         chk({tag, ".op"}, 32'(op_out0), 32'(o));
      end
   endtask

   // Single transaction into an empty pipeline with out_ready=1; result visible on return.
   task automatic run1(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
      in_valid = 1'b1; op = o; a = av; b = bv;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;

      // 1. reset
      tick();
      tick();
      chk("rst.in_ready0", 32'(in_ready0), 0);
      chk("rst.in_ready1", 32'(in_ready1), 0);
      chk_out("rst", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);
      chk("rst.result0", 32'(result0), 0);
      chk("rst.carry0", 32'(carry0), 0);
      reset = 1'b0;
      #1;
      chk("rst.in_ready_after", 32'(in_ready0 & in_ready1), 1);

      // 2. back-to-back ADD then SUB, 2-cycle latency
      out_ready = 1'b1;
      in_valid = 1'b1; op = 2'b00; a = 8'd4; b = 8'd7;
      tick();
      chk_out("b2b.lat", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);
      op = 2'b01; a = 8'd8; b = 8'd12;
      tick();
      in_valid = 1'b0;
      chk_out("b2b.add", 1'b1, 8'd11, 8'd11, 1'b0, 2'b00);
      tick();
      chk_out("b2b.sub", 1'b1, 8'd4, 8'd4, 1'b0, 2'b01);
      tick();
      chk_out("b2b.idle", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);

      // 3. carry / borrow with and without saturation
      run1(2'b00, 8'd200, 8'd100);
      chk_out("add.ovf", 1'b1, 8'd44, 8'd255, 1'b1, 2'b00);
      tick();
      run1(2'b01, 8'd12, 8'd8);
      chk_out("sub.brw", 1'b1, 8'd252, 8'd0, 1'b1, 2'b01);
      tick();

      // 4. CLR then three ACC a=100
      in_valid = 1'b1; op = 2'b11; a = 8'd9; b = 8'd9;
      tick();
      op = 2'b10; a = 8'd100;
      tick();
      chk_out("acc.clr", 1'b1, 8'd0, 8'd0, 1'b0, 2'b11);
      tick();
      chk_out("acc.1", 1'b1, 8'd100, 8'd100, 1'b0, 2'b10);
      tick();
      in_valid = 1'b0;
      chk_out("acc.2", 1'b1, 8'd200, 8'd200, 1'b0, 2'b10);
      tick();
      chk_out("acc.3", 1'b1, 8'd44, 8'd255, 1'b1, 2'b10);
      tick();
      chk_out("acc.idle", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);

      // 5. backpressure: only two accepted, then all three drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; op = 2'b00; a = 8'd1; b = 8'd2;
      #1;
      chk("bp.rdy1", 32'(in_ready0), 1);
      tick();
      a = 8'd3; b = 8'd4;
      #1;
      chk("bp.rdy2", 32'(in_ready0), 1);
      tick();
      op = 2'b01; a = 8'd1; b = 8'd10;
      #1;
      chk("bp.rdy3", 32'(in_ready0), 0);
      chk_out("bp.hold1", 1'b1, 8'd3, 8'd3, 1'b0, 2'b00);
      tick();
      tick();
      chk("bp.rdy3b", 32'(in_ready1), 0);
      chk_out("bp.hold2", 1'b1, 8'd3, 8'd3, 1'b0, 2'b00);
      out_ready = 1'b1;
      #1;
      chk("bp.rdy_release", 32'(in_ready0), 1);
      tick();
      in_valid = 1'b0;
      chk_out("bp.out2", 1'b1, 8'd7, 8'd7, 1'b0, 2'b00);
      tick();
      chk_out("bp.out3", 1'b1, 8'd9, 8'd9, 1'b0, 2'b01);
      tick();
      chk_out("bp.empty", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);

      // 6. reset with acc=50 and two ops in flight
      run1(2'b11, 8'd0, 8'd0);
      tick();
      run1(2'b10, 8'd50, 8'd0);
      chk_out("rst2.acc50", 1'b1, 8'd50, 8'd50, 1'b0, 2'b10);
      tick();
      out_ready = 1'b0;
      in_valid = 1'b1; op = 2'b00; a = 8'd5; b = 8'd6;
      tick();
      tick();
      in_valid = 1'b0;
      chk_out("rst2.inflight", 1'b1, 8'd11, 8'd11, 1'b0, 2'b00);
      reset = 1'b1;
      out_ready = 1'b1;
      tick();
      reset = 1'b0;
      chk_out("rst2.flush", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);
      tick();
      chk_out("rst2.flush2", 1'b0, 8'd0, 8'd0, 1'b0, 2'd0);
      run1(2'b10, 8'd5, 8'd0);
      chk_out("rst2.acc5", 1'b1, 8'd5, 8'd5, 1'b0, 2'b10);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
